// File: rtl/moa_pkg.sv
// Shared constants and elaboration-time sizing helpers for the multi-operand adder.
// Used by moa_add_level and multi_operand_adder_pipe.
package moa_pkg;

  localparam int MOA_N_OPS        = 19;
  localparam int MOA_W_IN         = 6;
  localparam int MOA_STAGE_LEVELS = 2;

  function automatic int moa_clog2(input int v);
    int r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int moa_w_out(input int n_ops, input int w_in);
    return w_in + moa_clog2(n_ops);
  endfunction

  function automatic int moa_lat(input int n_ops, input int stage_levels);
    return (moa_clog2(n_ops) + stage_levels - 1) / stage_levels;
  endfunction

  // Element count remaining after `level` pairwise-reduction levels.
  function automatic int moa_cnt(input int n_ops, input int level);
    int c = n_ops;
    for (int i = 0; i < level; i++) c = (c + 1) / 2;
    return c;
  endfunction

endpackage

// File: rtl/moa_add_level.sv
// One combinational adder-tree level: pairwise unsigned adds, each result one bit wider.
// An odd trailing element is zero-extended and passed through.
module moa_add_level
  import moa_pkg::*;
#(
  parameter int N = 2,
  parameter int W = 1
) (
  input  logic [N*W-1:0]               ops,
  output logic [((N+1)/2)*(W+1)-1:0]   sums
);

  localparam int NP = N / 2;

  for (genvar i = 0; i < NP; i++) begin : g_pair
    assign sums[i*(W+1) +: W+1] = {1'b0, ops[2*i*W +: W]} + {1'b0, ops[(2*i+1)*W +: W]};
  end

  if (N % 2 == 1) begin : g_odd
    assign sums[NP*(W+1) +: W+1] = {1'b0, ops[(N-1)*W +: W]};
  end

endmodule

// File: rtl/multi_operand_adder_pipe.sv
// Pipelined N_OPS x W_IN unsigned summer with valid/ready and a global stall.
// Build with MOA_SAT_EN defined to saturate sum_lo on overflow; otherwise sum_lo wraps.
module multi_operand_adder_pipe
  import moa_pkg::*;
#(
  parameter int N_OPS        = MOA_N_OPS,
  parameter int W_IN         = MOA_W_IN,
  parameter int STAGE_LEVELS = MOA_STAGE_LEVELS
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [N_OPS*W_IN-1:0]              ops_in,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [moa_w_out(N_OPS, W_IN)-1:0]  sum_full,
  output logic [W_IN-1:0]                    sum_lo,
  output logic                               ovf
);

  localparam int LEVELS = moa_clog2(N_OPS);
  localparam int W_OUT  = moa_w_out(N_OPS, W_IN);
  localparam int LAT    = moa_lat(N_OPS, STAGE_LEVELS);

  logic         adv;
  logic [LAT:1] vld_pipe;

  // Whole pipe moves together; bubbles are not squeezed out behind a stall.
  assign adv      = out_ready | ~out_valid;
  assign in_ready = adv;

  for (genvar l = 1; l <= LEVELS; l++) begin : g_lvl
    localparam int NI  = moa_cnt(N_OPS, l - 1);
    localparam int NO  = moa_cnt(N_OPS, l);
    localparam int WI  = W_IN + l - 1;
    localparam bit REG = (l % STAGE_LEVELS == 0) || (l == LEVELS);

    logic [NI*WI-1:0]     din;
    logic [NO*(WI+1)-1:0] sums;
    logic [NO*(WI+1)-1:0] q;

    if (l == 1) begin : g_src
      assign din = ops_in;
    end else begin : g_src
      assign din = g_lvl[l-1].q;
    end

    moa_add_level #(.N(NI), .W(WI)) u_add (
      .ops  (din),
      .sums (sums)
    );

    if (REG) begin : g_reg
      always_ff @(posedge clk) begin
        if (reset)    q <= '0;
        else if (adv) q <= sums;
      end
    end else begin : g_comb
      assign q = sums;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe <= '0;
    end else if (adv) begin
      vld_pipe[1] <= in_valid;
      for (int s = 2; s <= LAT; s++) vld_pipe[s] <= vld_pipe[s-1];
    end
  end

  assign out_valid = vld_pipe[LAT];
  assign sum_full  = g_lvl[LEVELS].q;
  assign ovf       = |sum_full[W_OUT-1:W_IN];

`ifdef MOA_SAT_EN
  assign sum_lo = ovf ? {W_IN{1'b1}} : sum_full[W_IN-1:0];
`else
  assign sum_lo = sum_full[W_IN-1:0];
`endif

endmodule

// File: tb/tb_multi_operand_adder_pipe.sv
// Self-checking bench: default 19x6 instance plus three parameter-sweep instances.
module tb_multi_operand_adder_pipe;

`ifdef MOA_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  localparam int N = 19;
  localparam int W = 6;
  localparam int LAT_DEF = 3;

  typedef struct { int full; int lo; bit ovf; int acc; } exp_t;
  typedef struct { logic [113:0] ops; exp_t e; } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset, in_valid, in_ready, out_valid, out_ready, ovf;
  logic [113:0] ops;
  logic [10:0]  sum_full;
  logic [5:0]   sum_lo;

  multi_operand_adder_pipe dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .ops_in(ops),
    .out_valid(out_valid), .out_ready(out_ready), .sum_full(sum_full), .sum_lo(sum_lo), .ovf(ovf)
  );

  // sweep instances share one operand bus; each has its own handshake
  logic [263:0] sw_bits;
  logic         sw_iv [3], sw_or [3], sw_ir [3], sw_ov [3], sw_ovf [3];
  logic [1:0]   s0_full;
  logic [0:0]   s0_lo;
  logic [6:0]   s1_full;
  logic [3:0]   s1_lo;
  logic [13:0]  s2_full;
  logic [7:0]   s2_lo;
  int           sw_sum [3], sw_lo [3];

  multi_operand_adder_pipe #(.N_OPS(2), .W_IN(1), .STAGE_LEVELS(1)) dut_s0 (
    .clk(clk), .reset(reset), .in_valid(sw_iv[0]), .in_ready(sw_ir[0]), .ops_in(sw_bits[1:0]),
    .out_valid(sw_ov[0]), .out_ready(sw_or[0]), .sum_full(s0_full), .sum_lo(s0_lo), .ovf(sw_ovf[0])
  );
  multi_operand_adder_pipe #(.N_OPS(8), .W_IN(4), .STAGE_LEVELS(3)) dut_s1 (
    .clk(clk), .reset(reset), .in_valid(sw_iv[1]), .in_ready(sw_ir[1]), .ops_in(sw_bits[31:0]),
    .out_valid(sw_ov[1]), .out_ready(sw_or[1]), .sum_full(s1_full), .sum_lo(s1_lo), .ovf(sw_ovf[1])
  );
  multi_operand_adder_pipe #(.N_OPS(33), .W_IN(8), .STAGE_LEVELS(1)) dut_s2 (
    .clk(clk), .reset(reset), .in_valid(sw_iv[2]), .in_ready(sw_ir[2]), .ops_in(sw_bits),
    .out_valid(sw_ov[2]), .out_ready(sw_or[2]), .sum_full(s2_full), .sum_lo(s2_lo), .ovf(sw_ovf[2])
  );

  always_comb begin
    sw_sum[0] = int'(s0_full); sw_lo[0] = int'(s0_lo);
    sw_sum[1] = int'(s1_full); sw_lo[1] = int'(s1_lo);
    sw_sum[2] = int'(s2_full); sw_lo[2] = int'(s2_lo);
  end

  int     total = 0, bad = 0, cyc = 0;
  exp_t   q [$];
  bit     lat_chk = 1'b0, stl = 1'b0;
  int     snap_full, snap_lo, snap_ovf;
  vec_t   tbl [5];

  task automatic chk(input string nm, input int act, input int exp_v);
    total++;
    if (act != exp_v) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", nm, act, exp_v, cyc);
    end
  endtask

  // Reference: plain sum of operands, then the legacy-width rules.
  function automatic exp_t model(input logic [113:0] o);
    exp_t e;
    int s = 0;
    for (int k = 0; k < N; k++) s += int'(o[k*W +: W]);
    e.full = s;
    e.ovf  = (s > 63);
    e.lo   = (s > 63) ? (SAT ? 63 : s % 64) : s;
    e.acc  = 0;
    return e;
  endfunction

  function automatic logic [113:0] rnd_ops();
    logic [113:0] o;
    for (int k = 0; k < N; k++) o[k*W +: W] = 6'($urandom);
    return o;
  endfunction

  // One cycle on the default instance: drive, check handshake and any emerging result, clock.
  task automatic step(input bit v, input logic [113:0] o, input bit r, input bit rst,
                      input exp_t ein, output bit acc);
    exp_t e;
    if (stl) begin
      chk("hold_valid", int'(out_valid), 1);
      chk("hold_full", int'(sum_full), snap_full);
      chk("hold_lo", int'(sum_lo), snap_lo);
      chk("hold_ovf", int'(ovf), snap_ovf);
    end
    reset = rst; in_valid = v; ops = o; out_ready = r;
    #1;
    acc = v && in_ready && !rst;
    chk("in_ready", int'(in_ready), int'(!(out_valid && !out_ready)));
    stl = 1'b0;
    if (rst) begin
      q.delete();
    end else begin
      if (q.size() == 0) chk("spurious_out", int'(out_valid), 0);
      else if (out_valid && out_ready) begin
        e = q.pop_front();
        chk("sum_full", int'(sum_full), e.full);
        chk("sum_lo", int'(sum_lo), e.lo);
        chk("ovf", int'(ovf), int'(e.ovf));
        if (lat_chk) chk("latency", cyc - e.acc, LAT_DEF);
      end
      if (acc) begin e = ein; e.acc = cyc; q.push_back(e); end
      stl = out_valid && !out_ready;
      snap_full = int'(sum_full); snap_lo = int'(sum_lo); snap_ovf = int'(ovf);
    end
    @(posedge clk); cyc++; #1;
  endtask

  task automatic fill(input int n, input int w, output int s);
    int v;
    s = 0;
    sw_bits = '0;
    for (int k = 0; k < n; k++) begin
      v = $urandom_range(0, (1 << w) - 1);
      s += v;
      for (int b = 0; b < w; b++) sw_bits[k*w + b] = v[b];
    end
  endtask

  task automatic sweep(input int i, input int n, input int w, input int lat);
    int s, mx, waited, e;
    int eq [$];
    mx = (1 << w) - 1;
    chk("sweep_in_ready", int'(sw_ir[i]), 1);
    fill(n, w, s); eq.push_back(s);
    sw_iv[i] = 1'b1;
    @(posedge clk); cyc++; #1;
    sw_iv[i] = 1'b0;
    waited = 1;
    while (!sw_ov[i] && waited < 20) begin @(posedge clk); cyc++; #1; waited++; end
    chk("sweep_lat", waited, lat);
    for (int c = 0; c < 16 + lat + 2; c++) begin
      if (eq.size() == 0) chk("sweep_spurious", int'(sw_ov[i]), 0);
      else if (sw_ov[i]) begin
        e = eq.pop_front();
        chk("sweep_full", sw_sum[i], e);
        chk("sweep_ovf", int'(sw_ovf[i]), int'(e > mx));
        chk("sweep_lo", sw_lo[i], (e > mx) ? (SAT ? mx : (e & mx)) : e);
      end
      if (c < 16) begin fill(n, w, s); eq.push_back(s); sw_iv[i] = 1'b1; end
      else sw_iv[i] = 1'b0;
      @(posedge clk); cyc++; #1;
    end
    chk("sweep_drain", eq.size(), 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    bit a;
    int n_acc;
    logic [113:0] o;
    exp_t ez;

    // hand-derived table: all-63, ramp 1..19, zeros, exactly 63, exactly 64
    for (int k = 0; k < N; k++) begin
      tbl[0].ops[k*W +: W] = 6'd63;
      tbl[1].ops[k*W +: W] = 6'(k + 1);
    end
    tbl[2].ops = '0;
    tbl[3].ops = '0; tbl[3].ops[5:0] = 6'd63;
    tbl[4].ops = '0; tbl[4].ops[5:0] = 6'd63; tbl[4].ops[11:6] = 6'd1;
    tbl[0].e = '{full: 1197, lo: SAT ? 63 : 45, ovf: 1'b1, acc: 0};
    tbl[1].e = '{full: 190,  lo: SAT ? 63 : 62, ovf: 1'b1, acc: 0};
    tbl[2].e = '{full: 0,    lo: 0,             ovf: 1'b0, acc: 0};
    tbl[3].e = '{full: 63,   lo: 63,            ovf: 1'b0, acc: 0};
    tbl[4].e = '{full: 64,   lo: SAT ? 63 : 0,  ovf: 1'b1, acc: 0};
    ez = '{full: 0, lo: 0, ovf: 1'b0, acc: 0};

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; ops = '0; sw_bits = '0;
    for (int i = 0; i < 3; i++) begin sw_iv[i] = 1'b0; sw_or[i] = 1'b1; end
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_sum_full", int'(sum_full), 0);
    chk("rst_sum_lo", int'(sum_lo), 0);
    chk("rst_ovf", int'(ovf), 0);
    reset = 1'b0;
    #1;
    chk("in_ready_after_reset", int'(in_ready), 1);

    // table vectors back-to-back: exact values, fixed latency, no gaps
    lat_chk = 1'b1;
    for (int i = 0; i < 5; i++) step(1'b1, tbl[i].ops, 1'b1, 1'b0, tbl[i].e, a);
    for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b1, 1'b0, ez, a);
    chk("table_drained", q.size(), 0);

    // random stream under random backpressure
    lat_chk = 1'b0;
    n_acc = 0;
    for (int c = 0; c < 300 && n_acc < 10; c++) begin
      o = rnd_ops();
      step($urandom_range(0, 3) != 0, o, 1'($urandom_range(0, 1)), 1'b0, model(o), a);
      if (a) n_acc++;
    end
    chk("bp_accepted", n_acc, 10);
    for (int c = 0; c < 100 && q.size() != 0; c++)
      step(1'b0, '0, 1'($urandom_range(0, 1)), 1'b0, ez, a);
    chk("bp_drained", q.size(), 0);

    // reset with three vectors in flight: they must never appear
    for (int i = 0; i < 3; i++) begin o = rnd_ops(); step(1'b1, o, 1'b1, 1'b0, model(o), a); end
    o = rnd_ops();
    step(1'b1, o, 1'b0, 1'b1, model(o), a);
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_sum_full", int'(sum_full), 0);
    chk("midrst_sum_lo", int'(sum_lo), 0);
    chk("midrst_ovf", int'(ovf), 0);
    for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1, 1'b0, ez, a);
    lat_chk = 1'b1;
    o = rnd_ops();
    step(1'b1, o, 1'b1, 1'b0, model(o), a);
    for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1, 1'b0, ez, a);
    chk("midrst_drained", q.size(), 0);

    // parameter sweep
    sweep(0, 2, 1, 1);
    sweep(1, 8, 4, 1);
    sweep(2, 33, 8, 6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
